// File: rtl/spi_rom_burst_reader.sv
// spi_rom_burst_reader
// Burst reader for a serial NOR flash. A start request sends the read opcode
// and the address MSB first on io[0]. In quad mode it then runs DUMMY_CLKS
// turnaround clocks. Finally it streams BURST_BYTES bytes back, either 1 bit
// per SCLK on io[1] (single Read) or 4 bits per SCLK on io[3:0] (Quad Output
// Fast Read).
//
// Parameters:
//   ADDR_W      24 or 32 (32 selects the 4-byte-address opcodes 0x13/0x6C)
//   BURST_BYTES 1..256 bytes per transaction
//   DUMMY_CLKS  0..15 turnaround SCLKs (quad mode only)
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   start, addr, quad   request; addr and quad are captured with start
//   busy                transaction in flight (low in the final-byte cycle)
//   data_out/data_valid received byte and its one-cycle strobe
//   done                pulses together with the final byte's strobe
//   spi_cs              chip select, active high
//   spi_sclk            serial clock (one SCLK period = 2 clk cycles)
//   spi_out0, spi_dir0  io[0] output value and direction (1 = input)
//   spi_in              {io3,io2,io1,io0} from the pads
//   data_ready          (only with SPI_ROM_STALL_EN) consumer back-pressure
//
// Optional feature macro: SPI_ROM_STALL_EN. When it is defined, a byte whose
// strobe meets data_ready=0 keeps data_valid high and data_out unchanged.
// While the byte is held, SCLK stays low and cs stays asserted. The final byte
// ends the transaction at once and is never held.
module spi_rom_burst_reader #(
  parameter int ADDR_W      = 24,
  parameter int BURST_BYTES = 16,
  parameter int DUMMY_CLKS  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic              quad,
`ifdef SPI_ROM_STALL_EN
  input  logic              data_ready,
`endif
  output logic              busy,
  output logic [7:0]        data_out,
  output logic              data_valid,
  output logic              done,
  output logic              spi_cs,
  output logic              spi_sclk,
  output logic              spi_out0,
  output logic              spi_dir0,
  input  logic [3:0]        spi_in
);

  localparam int          FRAME_W   = 8 + ADDR_W;
  localparam logic [7:0]  OP_SINGLE = (ADDR_W == 32) ? 8'h13 : 8'h03;
  localparam logic [7:0]  OP_QUAD   = (ADDR_W == 32) ? 8'h6C : 8'h6B;
  localparam logic [7:0]  LAST_BYTE = 8'(BURST_BYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA
  } state_t;

  state_t               state_reg;
  logic                 sclk_reg;
  logic                 cs_reg;
  logic                 busy_reg;
  logic                 dir0_reg;
  logic                 out0_reg;
  logic                 quad_reg;
  logic [FRAME_W-1:0]   frame_reg;     // opcode + address, shifted out MSB first
  logic [5:0]           cnt_reg;       // SCLKs left in the current phase/byte
  logic [7:0]           byte_cnt_reg;  // bytes left after the current one
  logic [7:0]           rx_reg;
  logic [7:0]           data_out_reg;
  logic                 valid_reg;
  logic                 done_reg;

  logic [7:0]           rx_shift;
  logic                 hold;

  // Next receive shift value at a sampling edge: one nibble in quad mode
  // (high nibble first), otherwise one bit from io[1].
  always_comb begin
    rx_shift = quad_reg ? {rx_reg[3:0], spi_in} : {rx_reg[6:0], spi_in[1]};
  end

`ifdef SPI_ROM_STALL_EN
  assign hold = valid_reg && !data_ready;
`else
  assign hold = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      sclk_reg     <= 1'b0;
      cs_reg       <= 1'b0;
      busy_reg     <= 1'b0;
      dir0_reg     <= 1'b0;
      out0_reg     <= 1'b0;
      quad_reg     <= 1'b0;
      frame_reg    <= '0;
      cnt_reg      <= '0;
      byte_cnt_reg <= '0;
      rx_reg       <= '0;
      data_out_reg <= '0;
      valid_reg    <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      done_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          sclk_reg <= 1'b0;
          if (start) begin
            state_reg    <= ST_CMD;
            cs_reg       <= 1'b1;
            busy_reg     <= 1'b1;
            dir0_reg     <= 1'b0;
            quad_reg     <= quad;
            frame_reg    <= {(quad ? OP_QUAD : OP_SINGLE), addr};
            out0_reg     <= quad ? OP_QUAD[7] : OP_SINGLE[7];
            cnt_reg      <= 6'd7;
            byte_cnt_reg <= LAST_BYTE;
          end
        end

        ST_CMD, ST_ADDR: begin
          sclk_reg <= ~sclk_reg;
          // End of a high half: present the next bit for the coming low half.
          if (sclk_reg) begin
            frame_reg <= frame_reg << 1;
            out0_reg  <= frame_reg[FRAME_W-2];
            cnt_reg   <= cnt_reg - 6'd1;
            if (cnt_reg == '0) begin
              if (state_reg == ST_CMD) begin
                state_reg <= ST_ADDR;
                cnt_reg   <= 6'(ADDR_W - 1);
              end else begin
                out0_reg <= 1'b0;
                dir0_reg <= quad_reg;
                if (quad_reg && (DUMMY_CLKS > 0)) begin
                  state_reg <= ST_DUMMY;
                  cnt_reg   <= 6'(DUMMY_CLKS - 1);
                end else begin
                  state_reg <= ST_DATA;
                  cnt_reg   <= quad_reg ? 6'd1 : 6'd7;
                end
              end
            end
          end
        end

        ST_DUMMY: begin
          sclk_reg <= ~sclk_reg;
          if (sclk_reg) begin
            cnt_reg <= cnt_reg - 6'd1;
            if (cnt_reg == '0) begin
              state_reg <= ST_DATA;
              cnt_reg   <= 6'd1;
            end
          end
        end

        ST_DATA: begin
          if (!sclk_reg) begin
            // A held byte keeps its strobe and freezes SCLK low; the low half
            // resumes in the cycle data_ready is seen high.
            if (hold) begin
              valid_reg <= 1'b1;
            end else begin
              sclk_reg <= 1'b1;
            end
          end else begin
            sclk_reg <= 1'b0;
            rx_reg   <= rx_shift;
            cnt_reg  <= cnt_reg - 6'd1;
            if (cnt_reg == '0) begin
              data_out_reg <= rx_shift;
              valid_reg    <= 1'b1;
              cnt_reg      <= quad_reg ? 6'd1 : 6'd7;
              if (byte_cnt_reg == '0) begin
                // Final byte: drop the bus in the strobe cycle so a new start
                // can be accepted immediately.
                state_reg <= ST_IDLE;
                done_reg  <= 1'b1;
                cs_reg    <= 1'b0;
                busy_reg  <= 1'b0;
                dir0_reg  <= 1'b0;
              end else begin
                byte_cnt_reg <= byte_cnt_reg - 8'd1;
              end
            end
          end
        end

        default: begin
          state_reg <= ST_IDLE;
          sclk_reg  <= 1'b0;
          cs_reg    <= 1'b0;
          busy_reg  <= 1'b0;
          dir0_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_reg;
  assign data_out   = data_out_reg;
  assign data_valid = valid_reg;
  assign done       = done_reg;
  assign spi_cs     = cs_reg;
  assign spi_sclk   = sclk_reg;
  assign spi_out0   = out0_reg;
  assign spi_dir0   = dir0_reg;

endmodule

// File: tb/tb_spi_rom_burst_reader.sv
// Bench for spi_rom_burst_reader (ADDR_W=24, BURST_BYTES=4, DUMMY_CLKS=8).
// A behavioural flash counts SCLK rising edges, decodes the opcode and address
// it receives, and drives read data. Per-cycle expectations come from the
// frame arithmetic of the protocol.
module tb_spi_rom_burst_reader;
  localparam int AW = 24;
  localparam int BB = 4;
  localparam int DC = 8;
  localparam int FW = 8 + AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] addr;
  logic          quad;
  logic [3:0]    spi_in = 4'h0;
  logic          busy, data_valid, done, spi_cs, spi_sclk, spi_out0, spi_dir0;
  logic [7:0]    data_out;
`ifdef SPI_ROM_STALL_EN
  logic          data_ready = 1'b1;
`endif

  spi_rom_burst_reader #(.ADDR_W(AW), .BURST_BYTES(BB), .DUMMY_CLKS(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .addr(addr), .quad(quad),
`ifdef SPI_ROM_STALL_EN
    .data_ready(data_ready),
`endif
    .busy(busy), .data_out(data_out), .data_valid(data_valid), .done(done),
    .spi_cs(spi_cs), .spi_sclk(spi_sclk), .spi_out0(spi_out0),
    .spi_dir0(spi_dir0), .spi_in(spi_in)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- flash contents ----------------
  logic [7:0] ovr [int];

  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    if (ovr.exists(int'(a))) return ovr[int'(a)];
    return a[7:0] ^ a[15:8] ^ {a[19:16], a[23:20]} ^ 8'h5C;
  endfunction

  // ---------------- behavioural flash ----------------
  int          fl_n = 0;
  logic [31:0] fl_ca = '0;
  logic        fl_prev = 1'b0;

  function automatic logic [3:0] flash_drive(input int n, input logic [31:0] ca);
    logic [3:0] r;
    logic [7:0] b;
    int ds, d;
    bit q;
    r  = 4'($urandom);
    q  = (ca[31:24] == 8'h6B);
    ds = FW + (q ? DC : 0);
    if (n < ds) return r;
    d = n - ds;
    if (q) begin
      b = flash_byte(ca[23:0] + 24'(d / 2));
      return (d % 2 == 0) ? b[7:4] : b[3:0];
    end
    b = flash_byte(ca[23:0] + 24'(d / 8));
    return {r[3:2], b[7 - (d % 8)], r[0]};
  endfunction

  always @(negedge clk) begin
    if (spi_cs !== 1'b1) begin
      fl_n  = 0;
      fl_ca = '0;
      spi_in = 4'($urandom);
    end else begin
      if (spi_sclk === 1'b1 && fl_prev === 1'b0) begin
        if (fl_n < FW) fl_ca = {fl_ca[30:0], spi_out0};
        fl_n++;
      end
      if (spi_sclk === 1'b0) spi_in = flash_drive(fl_n, fl_ca);
    end
    fl_prev = spi_sclk;
  end

  // ---------------- transaction checker ----------------
  int         obs_first, obs_last, obs_n, t0_next;
  logic [7:0] obs_b [BB];

  // Called at a negedge. Either issues start now or continues a start that was
  // already driven in the previous done cycle (pre=1).
  task automatic do_txn(input logic [23:0] a, input bit q, input logic [7:0] op,
                        input bit pre, input bit poke10, input bit chain,
                        input logic [23:0] na, input bit nq);
    int t0, first, last, sp, cpb, ds;
    bit act, is_v;
    logic [FW-1:0] frame;
    frame = {op, a};
    cpb   = q ? 2 : 8;
    ds    = q ? DC : 0;
    first = 2 * (FW + ds + cpb) + 1;
    sp    = 2 * cpb;
    last  = first + (BB - 1) * sp;
    if (pre) t0 = t0_next;
    else begin
      start = 1'b1; addr = a; quad = q; t0 = cyc;
    end
    obs_first = -1; obs_last = -1; obs_n = 0;
    for (int i = 1; i <= last; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (poke10 && i == 10) begin start = 1'b1; addr = ~a; quad = ~q; end
      if (poke10 && i == 11) start = 1'b0;
      act  = (i < last);
      is_v = (i >= first) && ((i - first) % sp == 0);
      chk("cycle", 32'(cyc - t0), 32'(i));
      chk("busy", busy, act);
      chk("cs", spi_cs, act);
      chk("sclk", spi_sclk, act && ((i - 1) % 2 == 1));
      chk("dir0", spi_dir0, act && q && (i >= 2 * FW + 1));
      chk("valid", data_valid, is_v);
      chk("done", done, i == last);
      if (i <= 2 * FW) chk("io0", spi_out0, frame[FW - 1 - (i - 1) / 2]);
      if (is_v) chk("data", data_out, flash_byte(a + 24'((i - first) / sp)));
      if (data_valid === 1'b1) begin
        if (obs_first < 0) obs_first = i;
        if (obs_n < BB) obs_b[obs_n] = data_out;
        obs_n++;
      end
      if (done === 1'b1) obs_last = i;
      if (i == last && chain) begin
        start = 1'b1; addr = na; quad = nq; t0_next = cyc;
      end
    end
    $display("txn addr=0x%06h quad=%0d first=%0d last=%0d bytes=%0d", a, q, obs_first, obs_last, obs_n);
  endtask

  typedef struct {
    logic [23:0] a;
    bit          q;
    logic [7:0]  op;
    bit          poke;
    int          first_t;
    int          last_t;
    logic [31:0] bytes;
  } vec_t;

  vec_t        vecs [3];
  int          t0;
  logic [23:0] cur_a, nxt_a;
  bit          cur_q, nxt_q, ch, pre;

  initial begin
    ovr[32'h123456] = 8'hA5; ovr[32'h123457] = 8'h5A;
    ovr[32'h123458] = 8'h01; ovr[32'h123459] = 8'hFE;
    ovr[32'h000010] = 8'h3C; ovr[32'h000011] = 8'hC3;
    ovr[32'h000012] = 8'h77; ovr[32'h000013] = 8'h88;

    vecs[0] = '{24'h123456, 1'b0, 8'h03, 1'b0, 81, 129, 32'hA55A01FE};
    vecs[1] = '{24'h000010, 1'b1, 8'h6B, 1'b1, 85, 97,  32'h3CC37788};
    vecs[2] = '{24'h123456, 1'b1, 8'h6B, 1'b0, 85, 97,  32'hA55A01FE};

    reset = 1'b1; start = 1'b0; addr = '0; quad = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0); chk("rst_cs", spi_cs, 0); chk("rst_sclk", spi_sclk, 0);
    chk("rst_valid", data_valid, 0); chk("rst_done", done, 0);
    chk("rst_dir0", spi_dir0, 0); chk("rst_out0", spi_out0, 0); chk("rst_data", data_out, 0);
    reset = 1'b0;
    @(negedge clk);

    // Table-driven transactions (vec 1 also pokes start at T10 while busy).
    for (int v = 0; v < 3; v++) begin
      @(negedge clk);
      do_txn(vecs[v].a, vecs[v].q, vecs[v].op, 1'b0, vecs[v].poke, 1'b0, '0, 1'b0);
      chk("first_t", 32'(obs_first), 32'(vecs[v].first_t));
      chk("last_t", 32'(obs_last), 32'(vecs[v].last_t));
      chk("nbytes", 32'(obs_n), BB);
      for (int j = 0; j < BB; j++) chk("tbl_byte", obs_b[j], vecs[v].bytes[31 - 8 * j -: 8]);
    end

    // Reset at T40 of a single read, then a clean frame started at T45.
    @(negedge clk);
    start = 1'b1; addr = 24'h123456; quad = 1'b0; t0 = cyc;
    for (int i = 1; i <= 44; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (i == 40) begin chk("pre_rst_cs", spi_cs, 1); reset = 1'b1; end
      if (i == 41) begin
        reset = 1'b0;
        chk("mid_rst_cs", spi_cs, 0); chk("mid_rst_busy", busy, 0);
        chk("mid_rst_sclk", spi_sclk, 0); chk("mid_rst_dir0", spi_dir0, 0);
      end
      if (i >= 41) begin
        chk("mid_rst_valid", data_valid, 0); chk("mid_rst_done", done, 0);
        chk("mid_rst_idle_cs", spi_cs, 0);
      end
    end
    do_txn(24'h123456, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("post_rst_n", 32'(obs_n), BB);

    // Back-to-back: start held in the done cycle, single then quad.
    @(negedge clk);
    do_txn(24'h000010, 1'b0, 8'h03, 1'b0, 1'b0, 1'b1, 24'h123456, 1'b1);
    do_txn(24'h123456, 1'b1, 8'h6B, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    chk("b2b_n", 32'(obs_n), BB);

    // Randomised transactions with random gaps, pokes and chaining.
    cur_a = 24'($urandom); cur_q = 1'($urandom); pre = 1'b0;
    for (int r = 0; r < 10; r++) begin
      nxt_a = 24'($urandom);
      nxt_q = 1'($urandom);
      ch    = (r < 9) && ($urandom_range(0, 2) == 0);
      if (!pre) repeat ($urandom_range(1, 3)) @(negedge clk);
      do_txn(cur_a, cur_q, cur_q ? 8'h6B : 8'h03, pre, 1'($urandom), ch, nxt_a, nxt_q);
      chk("rnd_n", 32'(obs_n), BB);
      pre = ch; cur_a = nxt_a; cur_q = nxt_q;
    end

`ifdef SPI_ROM_STALL_EN
    // Hold byte 1 (strobe at T97) with data_ready=0 for 10 cycles.
    repeat (2) @(negedge clk);
    start = 1'b1; addr = 24'h123456; quad = 1'b0; t0 = cyc;
    for (int i = 1; i <= 139; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (i == 97) data_ready = 1'b0;
      if (i == 107) data_ready = 1'b1;
      if (i >= 98 && i <= 107) begin
        chk("stall_sclk", spi_sclk, 0); chk("stall_cs", spi_cs, 1);
        chk("stall_valid", data_valid, 1); chk("stall_data", data_out, 8'h5A);
      end
      if (i == 123) begin chk("late_valid", data_valid, 1); chk("late_data", data_out, 8'h01); end
      if (i == 139) begin chk("late_done", done, 1); chk("late_last", data_out, 8'hFE); end
    end
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
